// File: rtl/ts_slot_arbiter_pkg.sv
// Shared definitions for the TS slot arbiter: packet constants, source codes,
// FSM states and the null-packet byte table.
package ts_slot_arbiter_pkg;

  localparam int         TS_PKT_LEN = 188;
  localparam logic [7:0] TS_SYNC    = 8'h47;

  // Null packet header after the sync byte: PID 0x1FFF, payload only, CC 0.
  localparam logic [7:0] NULL_HDR1  = 8'h1F;
  localparam logic [7:0] NULL_HDR2  = 8'hFF;
  localparam logic [7:0] NULL_HDR3  = 8'h10;
  localparam logic [7:0] NULL_STUFF = 8'hFF;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_TBL  = 2'd1,
    SRC_PAY  = 2'd2,
    SRC_NULL = 2'd3
  } src_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TBL_GO,
    ST_TBL_RUN,
    ST_PAY_RUN,
    ST_NULL_RUN
  } state_e;

  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    case (idx)
      8'd0:    return TS_SYNC;
      8'd1:    return NULL_HDR1;
      8'd2:    return NULL_HDR2;
      8'd3:    return NULL_HDR3;
      default: return NULL_STUFF;
    endcase
  endfunction

endpackage

// File: rtl/ts_slot_arbiter_null_gen.sv
// Null-packet byte generator: after i_start it presents one byte per clock
// for 188 clocks, with o_done marking the last byte.
module ts_null_gen
  import ts_slot_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic [7:0] o_byte,
  output logic       o_ena,
  output logic       o_done
);

  localparam logic [7:0] LAST_IDX = 8'(TS_PKT_LEN - 1);

  logic       r_active;
  logic [7:0] r_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_idx    <= 8'd0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_idx    <= 8'd0;
    end else if (r_active) begin
      if (r_idx == LAST_IDX) begin
        r_active <= 1'b0;
        r_idx    <= 8'd0;
      end else begin
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  assign o_byte = r_active ? null_byte(r_idx) : 8'h00;
  assign o_ena  = r_active;
  assign o_done = r_active && (r_idx == LAST_IDX);

endmodule

// File: rtl/ts_slot_arbiter.sv
// Grants each downstream TS slot to the table inserter, payload FIFO or null
// generator and merges the granted source onto a single byte stream.
module ts_slot_arbiter
  import ts_slot_arbiter_pkg::*;
#(
  parameter int MAX_TBL_RUN = 2,
  parameter int TBL_TIMEOUT = 1024,
  parameter bit NULL_FILL   = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SLOT_REQ,
  output logic       SLOT_BUSY,
  input  logic       TBL_READY,
  output logic       TBL_START,
  input  logic [7:0] TBL_DATA,
  input  logic       TBL_ENA,
  input  logic       TBL_SENT,
  input  logic       PAY_AVAIL,
  output logic       PAY_RD,
  input  logic [7:0] PAY_DATA,
  output logic [7:0] DATA_OUT,
  output logic       ENA_OUT,
  output logic       PSYNC_OUT,
  output logic [1:0] SRC_MON,
  output logic       ERR
);

  localparam int         RUN_W    = (MAX_TBL_RUN < 1) ? 1 : $clog2(MAX_TBL_RUN + 1);
  localparam int         TMR_W    = $clog2(TBL_TIMEOUT + 1);
  localparam logic [7:0] LAST_IDX = 8'(TS_PKT_LEN - 1);

  state_e           r_state;
  src_e             r_src;
  logic             r_req_pend;
  logic             r_busy;
  logic             r_tbl_start;
  logic             r_pay_rd;
  logic             r_pay_sel;
  logic             r_ena;
  logic             r_psync;
  logic             r_err;
  logic             r_last;
  logic [7:0]       r_data;
  logic [7:0]       r_byte_cnt;
  logic [RUN_W-1:0] r_tbl_run;
  logic [TMR_W-1:0] r_timer;

  src_e       w_grant;
  logic       w_to_idle;
  logic       w_err_set;
  logic [7:0] w_tbl_cnt_next;
  logic [7:0] w_null_byte;
  logic       w_null_ena;
  logic       w_null_done;

  assign w_tbl_cnt_next = r_byte_cnt + {7'd0, TBL_ENA};

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    w_grant = SRC_NONE;
    if (r_state == ST_IDLE && r_req_pend) begin
      if (TBL_READY && (r_tbl_run < RUN_W'(MAX_TBL_RUN) || !PAY_AVAIL))
        w_grant = SRC_TBL;
      else if (PAY_AVAIL)
        w_grant = SRC_PAY;
      else if (NULL_FILL)
        w_grant = SRC_NULL;
    end
  end

  always_comb begin
    w_to_idle = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      ST_TBL_RUN: begin
        w_to_idle = TBL_SENT || (r_timer == TMR_W'(TBL_TIMEOUT - 1));
        w_err_set = TBL_SENT ? (w_tbl_cnt_next != 8'(TS_PKT_LEN)) : w_to_idle;
      end
      ST_PAY_RUN, ST_NULL_RUN: w_to_idle = r_last;
      default: ;
    endcase
  end

  ts_null_gen u_null_gen (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_start (w_grant == SRC_NULL),
    .o_byte  (w_null_byte),
    .o_ena   (w_null_ena),
    .o_done  (w_null_done)
  );

  // NOTE: sequential state uses non-blocking assignments only; the per-cycle
  // defaults at the top are overridden by later assignments in the same block.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_src       <= SRC_NONE;
      r_req_pend  <= 1'b0;
      r_busy      <= 1'b0;
      r_tbl_start <= 1'b0;
      r_pay_rd    <= 1'b0;
      r_pay_sel   <= 1'b0;
      r_ena       <= 1'b0;
      r_psync     <= 1'b0;
      r_err       <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= 8'h00;
      r_byte_cnt  <= 8'd0;
      r_tbl_run   <= '0;
      r_timer     <= '0;
    end else begin
      r_tbl_start <= 1'b0;
      r_pay_sel   <= 1'b0;
      r_ena       <= 1'b0;
      r_psync     <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= 8'h00;

      // A request arriving while a slot is in flight is dropped, not queued.
      if (SLOT_REQ && !r_busy)
        r_req_pend <= 1'b1;
      else if (w_grant != SRC_NONE)
        r_req_pend <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          case (w_grant)
            SRC_TBL: begin
              r_state     <= ST_TBL_GO;
              r_tbl_start <= 1'b1;
              if (r_tbl_run < RUN_W'(MAX_TBL_RUN))
                r_tbl_run <= r_tbl_run + RUN_W'(1);
            end
            SRC_PAY: begin
              r_state   <= ST_PAY_RUN;
              r_pay_rd  <= 1'b1;
              r_tbl_run <= '0;
            end
            SRC_NULL: begin
              r_state   <= ST_NULL_RUN;
              r_tbl_run <= '0;
            end
            default: ;
          endcase
          if (w_grant != SRC_NONE) begin
            r_busy <= 1'b1;
            r_src  <= w_grant;
          end
        end

        ST_TBL_GO: begin
          r_state <= ST_TBL_RUN;
          r_timer <= TMR_W'(1);
        end

        ST_TBL_RUN: begin
          r_data  <= TBL_ENA ? TBL_DATA : 8'h00;
          r_ena   <= TBL_ENA;
          r_psync <= TBL_ENA && (r_byte_cnt == 8'd0);
          r_timer <= r_timer + TMR_W'(1);
          if (TBL_ENA)
            r_byte_cnt <= r_byte_cnt + 8'd1;
        end

        // The FIFO presents PAY_DATA one clock after PAY_RD; that byte passes
        // straight through the output mux under the registered r_pay_sel.
        ST_PAY_RUN: begin
          r_pay_sel <= r_pay_rd;
          r_ena     <= r_pay_rd;
          r_psync   <= r_pay_rd && (r_byte_cnt == 8'd0);
          if (r_pay_rd) begin
            r_byte_cnt <= r_byte_cnt + 8'd1;
            if (r_byte_cnt == LAST_IDX) begin
              r_pay_rd <= 1'b0;
              r_last   <= 1'b1;
            end
          end
        end

        ST_NULL_RUN: begin
          r_data  <= w_null_byte;
          r_ena   <= w_null_ena;
          r_psync <= w_null_ena && (r_byte_cnt == 8'd0);
          r_last  <= w_null_done;
          if (w_null_ena)
            r_byte_cnt <= r_byte_cnt + 8'd1;
        end

        default: r_state <= ST_IDLE;
      endcase

      if (w_err_set)
        r_err <= 1'b1;

      if (w_to_idle) begin
        r_state    <= ST_IDLE;
        r_busy     <= 1'b0;
        r_src      <= SRC_NONE;
        r_byte_cnt <= 8'd0;
      end
    end
  end

  assign SLOT_BUSY = r_busy;
  assign TBL_START = r_tbl_start;
  assign PAY_RD    = r_pay_rd;
  assign DATA_OUT  = r_pay_sel ? PAY_DATA : r_data;
  assign ENA_OUT   = r_ena;
  assign PSYNC_OUT = r_psync;
  assign SRC_MON   = r_src;
  assign ERR       = r_err;

endmodule
